// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front end with sub-word read-modify-write and load extension
module mem_access_unit #(
  parameter int READ_LAT = 1
) (
  input  logic        inclk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_datain,
  output logic        mem_we,
  input  logic [31:0] mem_dataout
);
  if (READ_LAT < 1 || READ_LAT > 7) begin : g_lat_chk
    $error("mem_access_unit: READ_LAT must be in 1..7");
  end
  typedef enum logic [1:0] {IDLE, RD_WAIT, WRITE, RESP} state_t;
  state_t state, nxt;
  logic [2:0] cnt;
  logic l_write, l_uns;
  logic [1:0] l_size, l_off;
  logic [31:0] l_wdata;
  logic mis, done, acc;
  logic [4:0] sh;
  logic [15:0] lane;
  logic [31:0] ext, mask, merged;
  assign acc = state == IDLE && req_valid;
  assign mis = (req_size == 2'b01 && req_addr[0]) || (req_size[1] && req_addr[1:0] != 2'b00);
  assign done = state == RD_WAIT && cnt == 3'd1;
  assign sh = {l_off, 3'b000};
  assign lane = 16'(mem_dataout >> sh);
  assign req_ready = state == IDLE && !reset;
  assign resp_valid = state == RESP;
  assign mem_we = state == WRITE;
  always_comb begin
    mask = l_size == 2'b00 ? 32'h0000_00ff : 32'h0000_ffff;
    ext = l_size == 2'b00 ? {{24{~l_uns & lane[7]}}, lane[7:0]} :
          l_size == 2'b01 ? {{16{~l_uns & lane[15]}}, lane} : mem_dataout;
    merged = (mem_dataout & ~(mask << sh)) | ((l_wdata & mask) << sh);
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = !req_valid ? IDLE : mis ? RESP : (req_write && req_size[1]) ? WRITE : RD_WAIT;
      RD_WAIT: nxt = !done ? RD_WAIT : l_write ? WRITE : RESP;
      WRITE:   nxt = RESP;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge inclk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge inclk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      l_write <= 1'b0;
      l_uns <= 1'b0;
      l_size <= '0;
      l_off <= '0;
      l_wdata <= '0;
      mem_addr <= '0;
      mem_datain <= '0;
      resp_rdata <= '0;
      resp_err <= 1'b0;
    end else begin
      if (acc) begin
        l_write <= req_write;
        l_uns <= req_unsigned;
        l_size <= req_size;
        l_off <= req_addr[1:0];
        l_wdata <= req_wdata;
        mem_addr <= {2'b00, req_addr[31:2]};
        mem_datain <= req_wdata;
        cnt <= 3'(READ_LAT);
        if (mis) begin
          resp_rdata <= '0;
          resp_err <= 1'b1;
        end
      end
      if (state == RD_WAIT) begin
        cnt <= cnt - 3'd1;
        if (done && l_write) mem_datain <= merged;
        if (done && !l_write) begin
          resp_rdata <= ext;
          resp_err <= 1'b0;
        end
      end
      if (state == WRITE) begin
        resp_rdata <= '0;
        resp_err <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized scoreboard bench against a byte-array reference model
module tb_mem_access_unit;
  localparam int L = 3;
  logic inclk = 0, reset = 1, req_valid = 0, req_write = 0, req_unsigned = 0;
  logic [1:0] req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic req_ready, resp_valid, resp_err, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_datain, mem_dataout;
  int checks = 0, failures = 0, cyc = 0, last_t = -1;
  logic [31:0] mem [16];
  logic [31:0] pipe [8];
  logic [7:0] rb [64];
  typedef struct {logic [31:0] rd; logic er; int c;} rexp_t;
  typedef struct {logic [31:0] a, d; int c;} wexp_t;
  rexp_t rq[$];
  wexp_t wq[$];
  rexp_t re;
  wexp_t we_e;
  mem_access_unit #(.READ_LAT(L)) dut (
    .inclk(inclk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr),
    .mem_datain(mem_datain), .mem_we(mem_we), .mem_dataout(mem_dataout)
  );
  always #5 inclk = ~inclk;
  always @(posedge inclk) cyc <= cyc + 1;
  always @(posedge inclk) begin
    if (mem_we) mem[mem_addr[3:0]] <= mem_datain;
    pipe[0] <= mem[mem_addr[3:0]];
    for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_dataout = L == 1 ? mem[mem_addr[3:0]] : pipe[L > 1 ? L - 2 : 0];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", n, a, e);
    end
  endtask
  function automatic logic [31:0] word(input int i);
    return {rb[4*i+3], rb[4*i+2], rb[4*i+1], rb[4*i]};
  endfunction
  always @(negedge inclk) if (!reset) begin
    if (resp_valid) begin
      if (rq.size() == 0) chk("resp_unexpected", 1, 0);
      else begin
        re = rq.pop_front();
        chk("resp_rdata", resp_rdata, re.rd);
        chk("resp_err", {31'b0, resp_err}, {31'b0, re.er});
        chk("resp_cycle", cyc, re.c);
      end
    end
    if (mem_we) begin
      if (wq.size() == 0) chk("write_unexpected", 1, 0);
      else begin
        we_e = wq.pop_front();
        chk("write_addr", mem_addr, we_e.a);
        chk("write_data", mem_datain, we_e.d);
        chk("write_cycle", cyc, we_e.c);
      end
    end
  end
  task automatic wait_ready();
    int n = 0;
    @(negedge inclk);
    while (!req_ready) begin
      if (++n > 200) begin
        $display("FAIL ready_timeout act=0 exp=1");
        $fatal(1, "ready timeout");
      end
      @(negedge inclk);
    end
  endtask
  task automatic issue(input bit w, input int sz, input bit u, input int a, input logic [31:0] d, input bit hold);
    int t, r, lat;
    bit mis;
    wait_ready();
    req_write = w; req_size = 2'(sz); req_unsigned = u; req_addr = 32'(a); req_wdata = d; req_valid = 1;
    @(posedge inclk); #1;
    t = cyc;
    if (!hold) req_valid = 0;
    if (hold && last_t >= 0) chk("accept_gap", 32'(t - last_t), L + 2);
    last_t = hold ? t : -1;
    mis = (sz == 1 && a % 2 != 0) || (sz >= 2 && a % 4 != 0);
    r = 0;
    if (mis) lat = 1;
    else if (w) begin
      rb[a] = d[7:0];
      if (sz >= 1) rb[a+1] = d[15:8];
      if (sz >= 2) begin rb[a+2] = d[23:16]; rb[a+3] = d[31:24]; end
      lat = sz >= 2 ? 2 : 2 + L;
      wq.push_back('{32'(a / 4), word(a / 4), t + lat - 2});
    end else begin
      lat = 1 + L;
      if (sz == 0) begin
        r = rb[a];
        if (!u && r >= 128) r -= 256;
      end else if (sz == 1) begin
        r = rb[a] + 256 * rb[a+1];
        if (!u && r >= 32768) r -= 65536;
      end else r = word(a / 4);
    end
    rq.push_back('{32'(r), mis, t + lat - 1});
  endtask
  task automatic drain();
    int n = 0;
    while ((rq.size() != 0 || wq.size() != 0) && n < 200) begin @(negedge inclk); n++; end
    chk("drain_pending", 32'(rq.size() + wq.size()), 0);
  endtask
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 0;
    for (int i = 0; i < 64; i++) rb[i] = 0;
    repeat (2) @(posedge inclk);
    #1;
    chk("rst_ready", {31'b0, req_ready}, 0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 0);
    chk("rst_mem_we", {31'b0, mem_we}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_datain", mem_datain, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_err", {31'b0, resp_err}, 0);
    @(negedge inclk); reset = 0; #1;
    chk("ready_after_rst", {31'b0, req_ready}, 1);
    issue(1, 2, 0, 4, 32'hDEADBEEF, 0);
    issue(0, 2, 0, 4, 0, 0);
    issue(1, 2, 0, 4, 32'h80FF7F01, 0);
    issue(0, 0, 0, 5, 0, 0);
    issue(0, 0, 0, 6, 0, 0);
    issue(0, 0, 1, 6, 0, 0);
    issue(0, 1, 0, 6, 0, 0);
    issue(0, 1, 1, 6, 0, 0);
    issue(1, 2, 0, 4, 32'h11223344, 0);
    issue(1, 0, 0, 6, 32'h000000AA, 0);
    issue(1, 1, 0, 4, 32'h0000BEEF, 0);
    issue(0, 2, 0, 4, 0, 0);
    issue(0, 1, 0, 3, 0, 0);
    issue(1, 2, 0, 6, 32'h12345678, 0);
    issue(0, 2, 0, 4, 0, 0);
    drain();
    for (int i = 0; i < 4; i++) issue(0, 2, 0, 4, 0, 1);
    req_valid = 0;
    issue(1, 0, 0, 9, 32'h5A, 1);
    req_valid = 0;
    drain();
    for (int i = 0; i < 200; i++)
      issue(1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 63), $urandom, 0);
    drain();
    wait_ready();
    req_write = 1; req_size = 0; req_addr = 4; req_wdata = 32'h55; req_valid = 1;
    @(posedge inclk); #1;
    req_valid = 0;
    @(negedge inclk);
    reset = 1; #1;
    chk("midrst_mem_we", {31'b0, mem_we}, 0);
    chk("midrst_resp_valid", {31'b0, resp_valid}, 0);
    chk("midrst_ready", {31'b0, req_ready}, 0);
    repeat (2) @(negedge inclk);
    reset = 0; #1;
    chk("midrst_ready_after", {31'b0, req_ready}, 1);
    repeat (12) @(negedge inclk);
    for (int i = 0; i < 16; i++) chk("mem_word", mem[i], word(i));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store front end that sits directly upstream of the word-wide data memory (memory_test) and drives its datain/addr/we/dataout interface.
- Accepts one byte, halfword or word request at a time from the datapath and converts the byte address into a memory word index.
- Performs read-modify-write for sub-word stores, because the memory has no byte enables, and sign- or zero-extends sub-word loads.
- Returns a one-cycle response pulse carrying read data or a misalignment error.

Parameters:
- READ_LAT, 1, memory read latency in cycles from mem_addr stable (mem_we=0) to mem_dataout valid; legal range 1..7.

Ports:
- inclk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept; equals (state==IDLE) && !reset.
- req_write  input  1  1=store, 0=load.
- req_size  input  2  00 byte, 01 half, 10 word; 11 is treated as word.
- req_unsigned  input  1  loads only: 1=zero-extend, 0=sign-extend.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, taken from the low-order bytes.
- resp_valid  output  1  one-cycle response pulse.
- resp_rdata  output  32  load result; 0 for stores and errors.
- resp_err  output  1  misaligned access; valid with resp_valid.
- mem_addr  output  32  word index = {2'b00, addr[31:2]}.
- mem_datain  output  32  write data to memory.
- mem_we  output  1  memory write enable.
- mem_dataout  input  32  read data from memory.

Behaviour:
- Reset (async): state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_addr=0, mem_datain=0, latched request cleared.
- Byte lanes are little-endian: byte n is bits [8n+7:8n]. Half n (n = addr[1]) is bits [16n+15:16n].
- Misalignment:
  - half with addr[0]=1 is an error.
  - word with addr[1:0]!=0 is an error.
  - an erroring request makes no memory access and mem_we stays 0.
- FSM has four states: IDLE, RD_WAIT, WRITE, RESP.
  - IDLE: req_ready=1. On req_valid at edge T, latch all req_* fields.
    - misaligned: go to RESP with err=1.
    - word store: go to WRITE.
    - any load or sub-word store: go to RD_WAIT and load counter with READ_LAT.
  - RD_WAIT: mem_addr holds the latched word index, mem_we=0.
    - Counter decrements each cycle; mem_dataout is sampled on the edge that ends the READ_LAT-th RD_WAIT cycle.
    - Load: extract the lane, extend it into the result register, go to RESP.
    - Sub-word store: replace the addressed lane in the sampled word with req_wdata[7:0] or [15:0], other lanes unchanged, go to WRITE.
  - WRITE: exactly one cycle with mem_we=1 and mem_datain = merged word (or full req_wdata for a word store); go to RESP. mem_we is 0 in every other state.
  - RESP: resp_valid=1 for exactly one cycle with resp_rdata and resp_err valid; go to IDLE. There is no response backpressure.
- resp_rdata and resp_err hold their last values after the pulse; they are only meaningful while resp_valid=1.
- Latency, counted from the accept edge T:
  - error: resp in T+1.
  - word store: WRITE T+1, resp T+2.
  - load: resp in T+1+READ_LAT.
  - sub-word store: WRITE in T+1+READ_LAT, resp in T+2+READ_LAT.
- Back-to-back requests: a new request can be accepted in the cycle after RESP. req_valid during non-IDLE states is ignored, not queued.
- Reset mid-operation: the transaction is aborted, no resp_valid is produced, and mem_we drops to 0 immediately. A partially merged store is never written.
- READ_LAT outside 1..7: simulation $error at time 0.

Test Plan:
- Word store then load: SW addr 0x4, data 0xDEADBEEF -> mem_we=1 one cycle, mem_addr=1, mem_datain=0xDEADBEEF, resp at T+2. Then LW addr 0x4 -> resp_rdata=0xDEADBEEF at T+1+READ_LAT.
- Sub-word loads, memory word 1 = 0x80FF7F01:
  - LB addr 0x5 -> 0x0000007F.
  - LB addr 0x6 -> 0xFFFFFFFF.
  - LBU addr 0x6 -> 0x000000FF.
  - LH addr 0x6 -> 0xFFFF80FF.
  - LHU addr 0x6 -> 0x000080FF.
- Sub-word store RMW, memory word 1 = 0x11223344:
  - SB addr 0x6, data 0xAA -> mem_datain=0x11AA3344.
  - SH addr 0x4, data 0xBEEF -> 0x11AABEEF.
  - Each with exactly one mem_we pulse.
- Misalignment: LH addr 0x3 and SW addr 0x6 -> resp_err=1 at T+1, resp_rdata=0, mem_we never asserted, memory unchanged.
- Latency sweep at READ_LAT=3: LW resp at T+4, SB resp at T+5. req_valid held high throughout -> exactly one accept per RESP->IDLE pass.
- Reset mid-op: assert reset during RD_WAIT of SB addr 0x4 -> mem_we=0 immediately, no resp_valid, memory word unchanged, req_ready=1 after reset deasserts.
